// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM states
//   req_id_e    : requester identity (fetch / data)
//   MODE_*      : access size/sign encoding carried on d_mode / mem_mode
//   LAT_MAX     : largest supported read latency (4-bit latency counter)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    localparam logic [2:0] MODE_BYTE   = 3'b000;
    localparam logic [2:0] MODE_HALF   = 3'b001;
    localparam logic [2:0] MODE_WORD   = 3'b010;
    localparam logic [2:0] MODE_BYTE_U = 3'b100;
    localparam logic [2:0] MODE_HALF_U = 3'b101;

    localparam int CNT_W   = 4;
    localparam int LAT_MAX = 15;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner select between instruction fetch and data access.
// Build option ARB_ROUND_ROBIN_EN: when defined, a last_winner flop (reset to
// REQ_IF) lets the requester that was not granted last win a tie, so a stream
// of data writes cannot starve fetch. When undefined, data always beats fetch
// and the module holds no state (clk/rst ports are then absent).
// Ports:
//   clk, rst : clock / async active-high reset (round-robin build only)
//   arb_en   : a grant may be issued this cycle (arbiter idle, not in reset)
//   if_req   : fetch request
//   d_req    : data request
//   if_win   : fetch is granted this cycle
//   d_win    : data is granted this cycle
// -----------------------------------------------------------------------------
module arb_pick
    import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic if_win,
    output logic d_win
);

`ifdef ARB_ROUND_ROBIN_EN
    req_id_e last_winner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner <= REQ_IF;
        end else if (if_win) begin
            last_winner <= REQ_IF;
        end else if (d_win) begin
            last_winner <= REQ_D;
        end
    end

    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (arb_en) begin
            if (if_req && d_req) begin
                // Tie goes to whoever did not win last time.
                if (last_winner == REQ_IF) begin
                    d_win = 1'b1;
                end else begin
                    if_win = 1'b1;
                end
            end else begin
                if_win = if_req;
                d_win  = d_req;
            end
        end
    end
`else
    // Data belongs to the older instruction, so it wins ties.
    assign d_win  = arb_en & d_req;
    assign if_win = arb_en & if_req & ~d_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (IF) and data
// access (MEM). Grants are combinational in the idle state; a read holds the
// port for LAT cycles and returns mem_rdata on the requester's rvalid, a write
// completes in its grant cycle. Also produces the IF/MEM stall requests.
// Build option ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (see
// arb_pick); the default is fixed data-over-fetch priority.
// Parameters: WIDTH (data bits), ADDR_WIDTH (address bits), LAT (1..15).
// Ports:
//   clk, rst                         : clock, async active-high reset
//   if_req/if_addr                   : fetch read request
//   if_gnt/if_rvalid/if_rdata        : fetch grant and read return
//   d_req/d_we/d_mode/d_addr/d_wdata : data request
//   d_gnt/d_rvalid/d_rdata           : data grant and read return
//   mem_req/mem_we/mem_mode/mem_addr/mem_wdata : memory command
//   mem_rdata                        : memory read data, LAT cycles after req
//   stall_f, stall_m                 : stall requests to the hazard unit
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LAT        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [WIDTH-1:0]      if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_mode,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0]      d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [WIDTH-1:0]      d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [2:0]            mem_mode,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  stall_f,
    output logic                  stall_m
);

    if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
        $error("mem_port_arbiter: LAT=%0d outside 1..%0d", LAT, LAT_MAX);
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    arb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             arb_en;
    logic             if_win;
    logic             d_win;
    logic             if_done;
    logic             d_done;

    assign arb_en  = (state == IDLE) & ~rst;
    assign if_done = (state == BUSY_IF) && (cnt == '0);
    assign d_done  = (state == BUSY_D) && (cnt == '0);

    arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .clk    (clk),
        .rst    (rst),
`endif
        .arb_en (arb_en),
        .if_req (if_req),
        .d_req  (d_req),
        .if_win (if_win),
        .d_win  (d_win)
    );

    // Sequencer: reads park the port for LAT cycles, writes never leave IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_win) begin
                        state <= BUSY_IF;
                        cnt   <= CNT_LOAD;
                    end else if (d_win && !d_we) begin
                        state <= BUSY_D;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs are forced to zero for as long as rst is high, not just after
    // the next edge, so the hazard unit never sees a stale grant or stall.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_mode  = 3'b000;
        mem_addr  = '0;
        mem_wdata = '0;
        stall_f   = 1'b0;
        stall_m   = 1'b0;
        if (!rst) begin
            if_gnt    = if_win;
            d_gnt     = d_win;
            if_rvalid = if_done;
            d_rvalid  = d_done;
            if_rdata  = if_done ? mem_rdata : '0;
            d_rdata   = d_done ? mem_rdata : '0;
            if (d_win) begin
                mem_req   = 1'b1;
                mem_we    = d_we;
                mem_mode  = d_mode;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else if (if_win) begin
                mem_req   = 1'b1;
                mem_mode  = MODE_WORD;
                mem_addr  = if_addr;
            end
            stall_f = if_req & ~if_done;
            // A data read keeps MEM stalled from its grant until its data returns.
            stall_m = (d_req & ~d_win) | (d_win & ~d_we) |
                      ((state == BUSY_D) & ~d_done);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NI = 2;   // instance 0: LAT=2, instance 1: LAT=1
    localparam int W  = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [2:0]    d_mode = 3'b010;
    logic [AW-1:0] d_addr = '0;
    logic [W-1:0]  d_wdata = '0;

    // staged inputs, applied shortly after each rising edge
    logic          s_rst = 1'b1;
    logic          s_if_req = 1'b0;
    logic [AW-1:0] s_if_addr = '0;
    logic          s_d_req = 1'b0;
    logic          s_d_we = 1'b0;
    logic [2:0]    s_d_mode = 3'b010;
    logic [AW-1:0] s_d_addr = '0;
    logic [W-1:0]  s_d_wdata = '0;

    logic [NI-1:0] if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, stall_f, stall_m;
    logic [W-1:0]  if_rdata [NI];
    logic [W-1:0]  d_rdata [NI];
    logic [2:0]    mem_mode [NI];
    logic [AW-1:0] mem_addr [NI];
    logic [W-1:0]  mem_wdata [NI];
    logic [W-1:0]  mem_rdata [NI];

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .LAT(2)) u_dut_lat2 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_mode(mem_mode[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .stall_f(stall_f[0]), .stall_m(stall_m[0])
    );

    mem_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_mode(mem_mode[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .stall_f(stall_f[1]), .stall_m(stall_m[1])
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // reference model: owner of the outstanding read (0 none, 1 IF, 2 D),
    // the cycle it was issued, its address, and the last tie winner (0 IF, 1 D)
    int            m_owner [NI];
    int            m_issue [NI];
    logic [AW-1:0] m_addr  [NI];
    int            m_last  [NI];
    int            nx_owner [NI];
    int            nx_issue [NI];
    logic [AW-1:0] nx_addr  [NI];
    int            nx_last  [NI];

    // memory environment: read-data delay line per instance
    logic          mp_v [NI][16];
    logic [W-1:0]  mp_d [NI][16];
    logic          cap_rd   [NI];
    logic [AW-1:0] cap_addr [NI];

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [W-1:0] mem_word(logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cyc %0d: got 0x%0h, want 0x%0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic evaluate(int k);
        int lat;
        logic busy, rv, w_if, w_d, e_req;
        logic [W-1:0] rdat;
        lat  = lat_of(k);
        busy = (m_owner[k] != 0);
        rv   = busy && (cyc == m_issue[k] + lat);
        rdat = rv ? mem_word(m_addr[k]) : '0;
        w_if = 1'b0;
        w_d  = 1'b0;
        if (!rst && !busy) begin
            if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                w_d  = (m_last[k] == 0);
                w_if = !w_d;
`else
                w_d  = 1'b1;
`endif
            end else begin
                w_if = if_req;
                w_d  = d_req;
            end
        end
        e_req = w_if | w_d;
        chk("if_gnt", k, if_gnt[k], w_if);
        chk("d_gnt", k, d_gnt[k], w_d);
        chk("mem_req", k, mem_req[k], e_req);
        chk("if_rvalid", k, if_rvalid[k], !rst && rv && m_owner[k] == 1);
        chk("d_rvalid", k, d_rvalid[k], !rst && rv && m_owner[k] == 2);
        chk("if_rdata", k, if_rdata[k], (!rst && m_owner[k] == 1) ? rdat : '0);
        chk("d_rdata", k, d_rdata[k], (!rst && m_owner[k] == 2) ? rdat : '0);
        chk("stall_f", k, stall_f[k], !rst && if_req && !(rv && m_owner[k] == 1));
        chk("stall_m", k, stall_m[k], !rst && ((d_req && !w_d) || (w_d && !d_we) ||
                                               (m_owner[k] == 2 && !rv)));
        if (e_req) begin
            chk("mem_addr", k, mem_addr[k], w_d ? d_addr : if_addr);
            chk("mem_we", k, mem_we[k], w_d && d_we);
            chk("mem_mode", k, mem_mode[k], w_d ? d_mode : 3'b010);
        end
        if (w_d) chk("mem_wdata", k, mem_wdata[k], d_wdata);
        if (!e_req) chk("mem_addr_idle", k, mem_addr[k], 0);

        cap_rd[k]   = mem_req[k] & ~mem_we[k];
        cap_addr[k] = mem_addr[k];

        nx_owner[k] = rv ? 0 : m_owner[k];
        nx_issue[k] = m_issue[k];
        nx_addr[k]  = m_addr[k];
        nx_last[k]  = m_last[k];
        if (w_if) begin
            nx_owner[k] = 1; nx_issue[k] = cyc; nx_addr[k] = if_addr; nx_last[k] = 0;
        end
        if (w_d) begin
            nx_last[k] = 1;
            if (!d_we) begin
                nx_owner[k] = 2; nx_issue[k] = cyc; nx_addr[k] = d_addr;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_owner[k] = 0;
                m_last[k]  = 0;
            end else begin
                m_owner[k] = nx_owner[k];
                m_issue[k] = nx_issue[k];
                m_addr[k]  = nx_addr[k];
                m_last[k]  = nx_last[k];
            end
            for (int i = 15; i > 0; i--) begin
                mp_v[k][i] = mp_v[k][i-1];
                mp_d[k][i] = mp_d[k][i-1];
            end
            mp_v[k][0] = cap_rd[k];
            mp_d[k][0] = mem_word(cap_addr[k]);
        end
        #1;
        rst = s_rst; if_req = s_if_req; if_addr = s_if_addr;
        d_req = s_d_req; d_we = s_d_we; d_mode = s_d_mode; d_addr = s_d_addr; d_wdata = s_d_wdata;
        for (int k = 0; k < NI; k++)
            mem_rdata[k] = mp_v[k][lat_of(k)-1] ? mp_d[k][lat_of(k)-1] : $urandom();
        @(negedge clk);
        for (int k = 0; k < NI; k++) evaluate(k);
    endtask

    task automatic idle(int n);
        s_if_req = 1'b0;
        s_d_req  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int if_cyc, nw, o0, o1, o2;
        for (int k = 0; k < NI; k++) begin
            m_owner[k] = 0; m_issue[k] = 0; m_addr[k] = '0; m_last[k] = 0;
            nx_owner[k] = 0; nx_issue[k] = 0; nx_addr[k] = '0; nx_last[k] = 0;
            cap_rd[k] = 1'b0; cap_addr[k] = '0; mem_rdata[k] = '0;
            for (int i = 0; i < 16; i++) begin mp_v[k][i] = 1'b0; mp_d[k][i] = '0; end
        end

        // reset with both requesters active: everything stays quiet
        s_rst = 1'b1; s_if_req = 1'b1; s_if_addr = 32'h40;
        s_d_req = 1'b1; s_d_we = 1'b0; s_d_addr = 32'h80;
        tick(); tick();
        chk("t1_if_gnt", 0, if_gnt[0], 0);
        chk("t1_d_gnt", 0, d_gnt[0], 0);
        chk("t1_mem_req", 0, mem_req[0], 0);
        chk("t1_stall_m", 0, stall_m[0], 0);
        s_rst = 1'b0; s_if_req = 1'b0;
        tick();
        chk("t1_d_gnt_after_release", 0, d_gnt[0], 1);
        idle(4);

        // single fetch, LAT=2
        s_if_req = 1'b1; s_if_addr = 32'h100;
        tick();
        chk("t2_if_gnt_c1", 0, if_gnt[0], 1);
        chk("t2_mem_req_c1", 0, mem_req[0], 1);
        chk("t2_stall_f_c1", 0, stall_f[0], 1);
        tick();
        chk("t2_stall_f_c2", 0, stall_f[0], 1);
        chk("t2_if_rvalid_c2", 0, if_rvalid[0], 0);
        tick();
        chk("t2_if_rvalid_c3", 0, if_rvalid[0], 1);
        chk("t2_if_rdata_c3", 0, if_rdata[0], 32'hDEAD_BEEF);
        chk("t2_stall_f_c3", 0, stall_f[0], 0);
        idle(4);

        // simultaneous fetch and data read
        s_if_req = 1'b1; s_if_addr = 32'h104;
        s_d_req = 1'b1; s_d_we = 1'b0; s_d_mode = 3'b010; s_d_addr = 32'h200;
        tick();
        chk("t3_d_gnt_c1", 0, d_gnt[0], 1);
        chk("t3_if_gnt_c1", 0, if_gnt[0], 0);
        s_d_req = 1'b0;
        tick(); tick();
        chk("t3_d_rvalid_c3", 0, d_rvalid[0], 1);
        chk("t3_d_rdata_c3", 0, d_rdata[0], mem_word(32'h200));
        tick();
        chk("t3_if_gnt_c4", 0, if_gnt[0], 1);
        chk("t3_mem_addr_c4", 0, mem_addr[0], 32'h104);
        s_if_req = 1'b0;
        tick(); tick();
        chk("t3_if_rvalid_c6", 0, if_rvalid[0], 1);
        chk("t3_if_rdata_c6", 0, if_rdata[0], mem_word(32'h104));
        idle(4);

        // write stream against a held fetch
        s_d_req = 1'b1; s_d_we = 1'b1; s_d_addr = 32'h300; s_d_wdata = $urandom();
        s_if_req = 1'b1; s_if_addr = 32'h180;
        nw = 0; if_cyc = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (d_gnt[0]) begin
                order.push_back(1);
                nw++;
                s_d_addr = s_d_addr + 4;
                s_d_wdata = $urandom();
                if (nw == 3) s_d_req = 1'b0;
            end
            if (if_gnt[0]) begin
                order.push_back(0);
                if_cyc = i;
                s_if_req = 1'b0;
            end
        end
        o0 = (order.size() > 0) ? order[0] : -1;
        o1 = (order.size() > 1) ? order[1] : -1;
        o2 = (order.size() > 2) ? order[2] : -1;
`ifdef ARB_ROUND_ROBIN_EN
        chk("t4_order0", 0, o0, 1);
        chk("t4_order1", 0, o1, 0);
        chk("t4_order2", 0, o2, 1);
        chk("t4_if_gnt_cycle", 0, if_cyc, 2);
`else
        chk("t4_order0", 0, o0, 1);
        chk("t4_order1", 0, o1, 1);
        chk("t4_order2", 0, o2, 1);
        chk("t4_if_gnt_cycle", 0, if_cyc, 4);
`endif
        s_d_we = 1'b0;
        idle(4);

        // reset pulse while a read is in flight
        s_if_req = 1'b1; s_if_addr = 32'h140;
        tick();
        chk("t5_if_gnt", 0, if_gnt[0], 1);
        s_if_req = 1'b0; s_rst = 1'b1;
        s_d_req = 1'b1; s_d_we = 1'b0; s_d_addr = 32'h208;
        tick();
        chk("t5_rst_d_gnt", 0, d_gnt[0], 0);
        chk("t5_rst_mem_req", 0, mem_req[0], 0);
        chk("t5_rst_stall_m", 0, stall_m[0], 0);
        chk("t5_rst_if_rvalid", 0, if_rvalid[0], 0);
        s_rst = 1'b0; s_d_req = 1'b0;
        tick();
        chk("t5_no_rvalid_t2", 0, if_rvalid[0], 0);
        tick();
        chk("t5_no_rvalid_t3", 0, if_rvalid[0], 0);
        s_d_req = 1'b1;
        tick();
        chk("t5_new_d_gnt", 0, d_gnt[0], 1);
        s_d_req = 1'b0;
        tick(); tick();
        chk("t5_new_d_rvalid", 0, d_rvalid[0], 1);
        chk("t5_new_d_rdata", 0, d_rdata[0], mem_word(32'h208));
        idle(4);

        // continuous data reads on the LAT=1 instance
        s_d_req = 1'b1; s_d_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_d_addr = 32'h400 + 4 * (i / 2);
            tick();
            chk("t6_d_gnt", 1, d_gnt[1], (i % 2) == 0);
            chk("t6_d_rvalid", 1, d_rvalid[1], (i % 2) == 1);
            if (i % 2 == 1) chk("t6_d_rdata", 1, d_rdata[1], mem_word(32'h400 + 4 * (i / 2)));
        end
        idle(4);

        // randomized traffic with occasional resets
        for (int c = 0; c < 450; c++) begin
            s_rst = ($urandom_range(0, 59) == 0);
            if (!(s_if_req && $urandom_range(0, 9) != 0)) begin
                s_if_req  = $urandom_range(0, 1);
                s_if_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            end
            if (!(s_d_req && $urandom_range(0, 9) != 0)) begin
                s_d_req   = $urandom_range(0, 1);
                s_d_we    = ($urandom_range(0, 2) == 0);
                s_d_mode  = 3'($urandom_range(0, 5));
                s_d_addr  = {20'h0, 12'($urandom_range(0, 4095))};
                s_d_wdata = $urandom();
            end
            tick();
        end
        s_rst = 1'b0;
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
